// File: rtl/arb_crossbar.sv
// PORT_N x PORT_N crossbar with one round-robin arbiter and one registered output slot per output.
// Optional U-turn forwarding (dest_i[k]==k) is enabled by defining ARB_CROSSBAR_UTURN_EN.
module arb_crossbar #(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_N     = 5,
  parameter int DEST_W     = $clog2(PORT_N)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [PORT_N*DATA_WIDTH-1:0] data_i,
  input  logic [PORT_N*DEST_W-1:0]     dest_i,
  input  logic [PORT_N-1:0]            valid_i,
  output logic [PORT_N-1:0]            ready_o,
  output logic [PORT_N*DATA_WIDTH-1:0] data_o,
  output logic [PORT_N-1:0]            valid_o,
  input  logic [PORT_N-1:0]            ready_i,
  output logic [PORT_N-1:0]            drop_o
);

  localparam int IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

  logic [DEST_W-1:0]     dest_arr [PORT_N];
  logic [DATA_WIDTH-1:0] data_arr [PORT_N];
  logic [PORT_N-1:0]     bad;
  logic [PORT_N-1:0]     req      [PORT_N];
  logic [IDX_W-1:0]      win_idx  [PORT_N];
  logic [PORT_N-1:0]     win_any;
  logic [PORT_N-1:0]     out_free;
  logic [PORT_N-1:0]     grant;

  logic [DATA_WIDTH-1:0] data_q   [PORT_N];
  logic [DATA_WIDTH-1:0] data_d   [PORT_N];
  logic [IDX_W-1:0]      ptr_q    [PORT_N];
  logic [IDX_W-1:0]      ptr_d    [PORT_N];
  logic [PORT_N-1:0]     valid_q, valid_d;
  logic [PORT_N-1:0]     drop_q, drop_d;

  for (genvar gi = 0; gi < PORT_N; gi++) begin : g_port
    assign dest_arr[gi] = dest_i[gi*DEST_W +: DEST_W];
    assign data_arr[gi] = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    // Requests that are accepted but never reach an arbiter
`ifdef ARB_CROSSBAR_UTURN_EN
    assign bad[gi] = valid_i[gi] && (int'(dest_arr[gi]) >= PORT_N);
`else
    assign bad[gi] = valid_i[gi] && ((int'(dest_arr[gi]) >= PORT_N) || (int'(dest_arr[gi]) == gi));
`endif
    assign out_free[gi] = !valid_q[gi] || ready_i[gi];
    assign grant[gi]    = win_any[gi] && out_free[gi];
    assign data_o[gi*DATA_WIDTH +: DATA_WIDTH] = data_q[gi];
  end

  assign valid_o = valid_q;
  assign drop_o  = drop_q;

  always_comb begin
    for (int j = 0; j < PORT_N; j++) begin
      req[j] = '0;
      for (int k = 0; k < PORT_N; k++) begin
        req[j][k] = valid_i[k] && !bad[k] && (int'(dest_arr[k]) == j);
      end
    end
  end

  // Per-output search starting at ptr, wrapping; first requester found wins
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    for (int j = 0; j < PORT_N; j++) begin
      win_any[j] = 1'b0;
      win_idx[j] = '0;
      for (int off = 0; off < PORT_N; off++) begin
        cand = int'(ptr_q[j]) + off;
        if (cand >= PORT_N) cand = cand - PORT_N;
        cand_idx = IDX_W'(cand);
        if (!win_any[j] && req[j][cand_idx]) begin
          win_any[j] = 1'b1;
          win_idx[j] = cand_idx;
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (!rst_i) begin
      ready_o = bad;
      for (int j = 0; j < PORT_N; j++) begin
        if (grant[j]) ready_o[win_idx[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    drop_d  = bad;
    for (int j = 0; j < PORT_N; j++) begin
      data_d[j] = data_q[j];
      ptr_d[j]  = ptr_q[j];
      if (grant[j]) begin
        data_d[j]  = data_arr[win_idx[j]];
        valid_d[j] = 1'b1;
        ptr_d[j]   = (int'(win_idx[j]) == PORT_N - 1) ? '0 : win_idx[j] + 1'b1;
      end else if (ready_i[j]) begin
        valid_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      drop_q  <= '0;
      for (int j = 0; j < PORT_N; j++) begin
        data_q[j] <= '0;
        ptr_q[j]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      drop_q  <= drop_d;
      for (int j = 0; j < PORT_N; j++) begin
        data_q[j] <= data_d[j];
        ptr_q[j]  <= ptr_d[j];
      end
    end
  end

endmodule

// File: tb/tb_arb_crossbar.sv
// Scoreboard bench for arb_crossbar (PORT_N=5, DATA_WIDTH=8): directed vectors push expectations,
// a negedge monitor pops them on every output handshake and drop pulse.
module tb_arb_crossbar;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int DWD = 3;
`ifdef ARB_CROSSBAR_UTURN_EN
  localparam bit UTURN = 1'b1;
`else
  localparam bit UTURN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N*DW-1:0]  data_i = '0;
  logic [N*DWD-1:0] dest_i = '0;
  logic [N-1:0]     valid_i = '0;
  logic [N-1:0]     ready_o;
  logic [N*DW-1:0]  data_o;
  logic [N-1:0]     valid_o;
  logic [N-1:0]     ready_i = '1;
  logic [N-1:0]     drop_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [N][$];
  int         drop_q [$];

  arb_crossbar #(.DATA_WIDTH(DW), .PORT_N(N)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .dest_i(dest_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every output handshake and drop pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        if (valid_o[j] && ready_i[j]) begin
          checks++;
          if (exp_q[j].size() == 0) begin
            errors++;
            $display("FAIL out%0d: unexpected packet %0h", j, data_o[j*DW +: DW]);
          end else begin
            logic [7:0] e;
            e = exp_q[j].pop_front();
            if (data_o[j*DW +: DW] !== e) begin
              errors++;
              $display("FAIL out%0d: got %0h expected %0h", j, data_o[j*DW +: DW], e);
            end else $display("ok   out%0d: %0h", j, e);
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (drop_o[k]) begin
          checks++;
          if (drop_q.size() == 0 || drop_q[0] != k) begin
            errors++;
            $display("FAIL drop: got pulse on %0d, expected queue head %0d", k,
                     (drop_q.size() == 0) ? -1 : drop_q[0]);
          end else begin
            void'(drop_q.pop_front());
            $display("ok   drop%0d", k);
          end
        end
      end
    end
  end

  function automatic logic [N*DW-1:0] mkdata(input int c);
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = 8'(c * 16 + k);
    return d;
  endfunction

  // One stimulus cycle: drive, check ready_o mid-cycle, push expectations, advance past the edge
  task automatic xfer(input string name, input logic [N-1:0] v, input logic [N*DWD-1:0] d,
                      input logic [N*DW-1:0] dat, input logic [N-1:0] exp_rdy);
    int dk;
    valid_i = v;
    dest_i  = d;
    data_i  = dat;
    @(negedge clk);
    chk({name, " ready_o"}, 64'(ready_o), 64'(exp_rdy));
    for (int k = 0; k < N; k++) begin
      if (exp_rdy[k]) begin
        dk = int'(d[k*DWD +: DWD]);
        if (dk >= N || (!UTURN && dk == k)) drop_q.push_back(k);
        else exp_q[dk].push_back(dat[k*DW +: DW]);
      end
    end
    @(posedge clk);
    #1;
    valid_i = '0;
  endtask

  task automatic idle(input string name);
    xfer(name, 5'b00000, '0, '0, 5'b00000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs cleared and ready_o low even with requests present
    #1 rst = 1'b1;
    valid_i = 5'b11111;
    dest_i  = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    data_i  = mkdata(15);
    #2;
    chk("reset ready_o", 64'(ready_o), 64'h0);
    chk("reset valid_o", 64'(valid_o), 64'h0);
    chk("reset data_o",  64'(data_o),  64'h0);
    chk("reset drop_o",  64'(drop_o),  64'h0);
    valid_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Contention on output 2 from inputs 1,3,4 starting at ptr 0: order 1,3,4,1
    ready_i = 5'b11111;
    xfer("cont1", 5'b11010, {5{3'd2}}, mkdata(1), 5'b00010);
    xfer("cont2", 5'b11010, {5{3'd2}}, mkdata(2), 5'b01000);
    xfer("cont3", 5'b11010, {5{3'd2}}, mkdata(3), 5'b10000);
    xfer("cont4", 5'b11010, {5{3'd2}}, mkdata(4), 5'b00010);
    idle("cont_drain");

    // Parallel: every input to a distinct output in the same cycle
    xfer("par", 5'b11111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, mkdata(5), 5'b11111);
    chk("par valid_o", 64'(valid_o), 64'h1f);
    idle("par_drain");
    chk("par cleared valid_o", 64'(valid_o), 64'h0);

    // Backpressure on output 0
    ready_i = 5'b11110;
    xfer("bp_load", 5'b00010, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, {8'h0, 8'h0, 8'h0, 8'hA5, 8'h0}, 5'b00010);
    for (int c = 0; c < 3; c++) begin
      xfer("bp_stall", 5'b00100, '0, {8'h0, 8'h0, 8'h5A, 8'h0, 8'h0}, 5'b00000);
      chk("bp data_o0 held", 64'(data_o[0 +: DW]), 64'hA5);
      chk("bp valid_o0 held", 64'(valid_o[0]), 64'h1);
    end
    ready_i = 5'b11111;
    xfer("bp_release", 5'b00100, '0, {8'h0, 8'h0, 8'h5A, 8'h0, 8'h0}, 5'b00100);
    chk("bp new data_o0", 64'(data_o[0 +: DW]), 64'h5A);
    idle("bp_drain");
    chk("drain valid_o0", 64'(valid_o[0]), 64'h0);
    chk("drain data_o0 held", 64'(data_o[0 +: DW]), 64'h5A);

    // Out-of-range destination: accepted, dropped, no output activity
    xfer("bad_dest", 5'b01000, {3'd0, 3'd7, 3'd0, 3'd0, 3'd0}, mkdata(6), 5'b01000);
    chk("bad_dest valid_o", 64'(valid_o), 64'h0);
    chk("bad_dest drop_o", 64'(drop_o), 64'h08);
    idle("bad_dest_after");
    chk("bad_dest drop one cycle", 64'(drop_o), 64'h0);

    // U-turn: forwarded or dropped depending on build
    xfer("uturn", 5'b00010, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, mkdata(7), 5'b00010);
    chk("uturn valid_o", 64'(valid_o), UTURN ? 64'h02 : 64'h00);
    chk("uturn drop_o",  64'(drop_o),  UTURN ? 64'h00 : 64'h02);
    idle("uturn_drain");

    // Reset mid-traffic with valid_o = 10110 held by backpressure
    ready_i = 5'b00000;
    xfer("pre_rst", 5'b01011, {3'd0, 3'd4, 3'd0, 3'd2, 3'd1}, mkdata(8), 5'b01011);
    chk("pre_rst valid_o", 64'(valid_o), 64'h16);
    valid_i = 5'b00100;
    dest_i  = {3'd0, 3'd0, 3'd3, 3'd0, 3'd0};
    #1;
    chk("pre_rst ready_o", 64'(ready_o), 64'h04);
    rst = 1'b1;
    for (int j = 0; j < N; j++) exp_q[j].delete();
    drop_q.delete();
    #1;
    chk("mid_rst valid_o", 64'(valid_o), 64'h0);
    chk("mid_rst drop_o",  64'(drop_o),  64'h0);
    chk("mid_rst ready_o", 64'(ready_o), 64'h0);
    chk("mid_rst data_o",  64'(data_o),  64'h0);
    valid_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i = 5'b11111;
    // Pointer for output 2 must be back at 0, so input 1 wins over input 3
    xfer("post_rst", 5'b01010, {5{3'd2}}, mkdata(9), 5'b00010);
    idle("post_rst_drain1");
    idle("post_rst_drain2");

    begin
      int left;
      left = 0;
      for (int j = 0; j < N; j++) left += exp_q[j].size();
      chk("pending packets", 64'(left), 64'h0);
      chk("pending drops", 64'(drop_q.size()), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_crossbar.md
ARB_CROSSBAR -- requirements
Module: arb_crossbar

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one packet.
REQ-002 SHALL have parameter PORT_N, default 5, number of input and output ports (2..16).
REQ-003 SHALL have parameter DEST_W, default $clog2(PORT_N), width of one destination field.
REQ-004 SHALL have port clk_i  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_i  input  PORT_N*DATA_WIDTH  input packets; port k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
REQ-007 SHALL have port dest_i  input  PORT_N*DEST_W  destination output index per input, packed the same way.
REQ-008 SHALL have port valid_i  input  PORT_N  per-input request.
REQ-009 SHALL have port ready_o  output  PORT_N  per-input accept; a transfer occurs when valid_i[k] && ready_o[k].
REQ-010 SHALL have port data_o  output  PORT_N*DATA_WIDTH  registered output packets, packed as data_i.
REQ-011 SHALL have port valid_o  output  PORT_N  per-output valid, registered.
REQ-012 SHALL have port ready_i  input  PORT_N  per-output downstream accept.
REQ-013 SHALL have port drop_o  output  PORT_N  registered one-cycle pulse per input whose accepted packet was discarded.

Function
REQ-014 SHALL service up to PORT_N simultaneous non-conflicting input-to-output connections per cycle.
REQ-015 SHALL, per output j, run an independent round-robin arbiter over inputs k with valid_i[k] && dest_i[k]==j.
REQ-016 Arbiter j SHALL search from input ptr_j upward, wrapping at PORT_N-1 to 0; first requester wins.
REQ-017 Output j SHALL be free when !valid_o[j] || ready_i[j]; ready_o[k] SHALL be 1 only if k won its output and that output is free.
REQ-018 ready_o SHALL be combinational from valid_i, dest_i, ready_i and arbiter state; it SHALL NOT depend on data_i.
REQ-019 On a transfer from k to j, output register j SHALL load data_i[k] and set valid_o[j]=1 next cycle (latency 1 cycle).
REQ-020 On a transfer, ptr_j SHALL become (k+1) mod PORT_N; ptr_j SHALL be unchanged when no grant occurs on j.
REQ-021 When valid_o[j] && ready_i[j] with no new grant, valid_o[j] SHALL clear next cycle; data_o[j] SHALL hold its value.
REQ-022 Simultaneous drain and grant on j SHALL load the new packet with no bubble (full throughput per output).
REQ-023 While valid_o[j] && !ready_i[j], data_o[j] and valid_o[j] SHALL be held stable.
REQ-024 A request with dest_i[k] >= PORT_N SHALL be accepted (ready_o[k]=1), discarded, and drop_o[k] pulsed next cycle.
REQ-025 ready_o[k] SHALL NOT be asserted while valid_i[k]==0.

Reset
REQ-026 While rst_i is high: valid_o=0, data_o=0, drop_o=0, all ptr_j=0, independent of clk_i.
REQ-027 ready_o SHALL be 0 while rst_i is high; packets held in output registers at reset assertion SHALL be lost.
REQ-028 First grant SHALL be possible on the first rising edge after rst_i deasserts.

Configuration
REQ-029 Macro ARB_CROSSBAR_UTURN_EN SHALL control U-turn routing (dest_i[k]==k).
REQ-030 With ARB_CROSSBAR_UTURN_EN defined, U-turn requests SHALL be arbitrated and forwarded like any other.
REQ-031 Without it, U-turn requests SHALL be accepted immediately, discarded, and drop_o[k] pulsed next cycle; they SHALL NOT enter arbitration.

Verification
REQ-032 Reset mid-traffic: rst_i high asynchronously between edges with valid_o=5'b10110 -> valid_o=0, drop_o=0, ready_o=0 immediately.
REQ-033 Parallel: inputs 0..4 valid, dest={1,2,3,4,0}, ready_i all 1 -> all ready_o=1; next cycle data_o[j] equals data of input (j-1) mod 5, valid_o=5'b11111.
REQ-034 Contention: inputs 1,3,4 all dest 2, ready_i=1, held valid -> grants to output 2 in order 1,3,4,1, one per cycle.
REQ-035 Backpressure: output 0 holds 8'hA5, ready_i[0]=0 for 3 cycles while input 2 requests dest 0 -> ready_o[2]=0, data_o[0]=8'hA5 stable; on ready_i[0]=1, same-cycle grant, next cycle new data.
REQ-036 Bad/U-turn dest: input 3 dest 7 (PORT_N=5) -> ready_o[3]=1, drop_o[3] one cycle, no valid_o change; input 1 dest 1 -> forwarded to output 1 with ARB_CROSSBAR_UTURN_EN, dropped with drop_o[1] pulse without it.
